rotate_left_seq: RTL and testbench

// - Multi-cycle rotate-left unit; the left-direction counterpart of the combinational rotate-right in the shifter datapath.
// - Takes a 16-bit operand and a 4-bit count on a start pulse and iterates to the result, 4 bits or 1 bit per cycle.
// - Output is held stable until the next accepted start.
// - Sits beside the ALU shifter for multi-cycle ROL/SLL execution; the pipeline stalls on busy.
//

---
 rtl/rotate_left_seq_pkg.sv | 17 +
 rtl/rotl_step.sv | 30 +++
 rtl/rotate_left_seq.sv | 120 ++++++++++++
 tb/tb_rotate_left_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_left_seq_pkg.sv
// Shared definitions for the multi-cycle rotate-left unit.
// The FSM state encoding and the two step sizes live here.
// Both the top level and the step datapath use them.
package rotate_left_seq_pkg;

    // The encodings are fixed so that waveforms and external probes stay readable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bits moved per RUN cycle: the coarse step first, then the fine step for the remainder.
    localparam int STEP_BIG   = 4;
    localparam int STEP_SMALL = 1;

endpackage : rotate_left_seq_pkg

// File: rtl/rotl_step.sv
// One iteration of the rotate-left datapath (purely combinational).
// The data word moves left by STEP_BIG bits when big_i is high, and by STEP_SMALL bits otherwise.
// When fill_zero_i is high, the vacated LSBs are filled with zeros (logical shift).
// When fill_zero_i is low, the bits that leave the MSB re-enter at the LSB.
module rotl_step
    import rotate_left_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             big_i,
    input  logic             fill_zero_i,
    output logic [WIDTH-1:0] next_o
);

    logic [STEP_BIG-1:0]   wrap_big;
    logic [STEP_SMALL-1:0] wrap_small;
    logic [WIDTH-1:0]      rot_big;
    logic [WIDTH-1:0]      rot_small;

    // The bits that leave the top re-enter at the bottom, unless zero fill is selected.
    assign wrap_big   = fill_zero_i ? {STEP_BIG{1'b0}}   : data_i[WIDTH-1 -: STEP_BIG];
    assign wrap_small = fill_zero_i ? {STEP_SMALL{1'b0}} : data_i[WIDTH-1 -: STEP_SMALL];

    assign rot_big   = {data_i[WIDTH-1-STEP_BIG:0],   wrap_big};
    assign rot_small = {data_i[WIDTH-1-STEP_SMALL:0], wrap_small};

    assign next_o = big_i ? rot_big : rot_small;

endmodule : rotl_step

// File: rtl/rotate_left_seq.sv
// Multi-cycle rotate-left unit. It sits beside the ALU shifter for ROL/SLL.
//
// Operation:
// - An accepted start loads the operand and the count.
// - The unit then rotates by 4 bits per cycle while at least 4 positions remain.
// - After that it rotates by 1 bit per cycle until the count is exhausted.
// - It then pulses done for one cycle.
// - out is the data register itself, so the result holds until the next accepted start.
// - start is accepted only in IDLE or DONE. A start raised in the DONE cycle begins the next operation with no gap.
//
// Optional feature: define ROTL_SHIFT_MODE_EN to add the shl input.
// - shl is captured together with in and cnt.
// - shl = 1 selects a logical shift left (zero fill) instead of a rotate.
// - Latency is the same in both modes.
module rotate_left_seq
    import rotate_left_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
`ifdef ROTL_SHIFT_MODE_EN
    input  logic             shl,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] BIG_CNT   = CNT_W'(STEP_BIG);
    localparam logic [CNT_W-1:0] SMALL_CNT = CNT_W'(STEP_SMALL);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             step_big;
    logic             fill_zero;

`ifdef ROTL_SHIFT_MODE_EN
    logic shl_q;

    // Capture the shift/rotate selection only when an operation is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shl_q <= 1'b0;
        end else if (start && (state_q != ST_RUN)) begin
            shl_q <= shl;
        end
    end

    assign fill_zero = shl_q;
`else
    assign fill_zero = 1'b0;
`endif

    // Take the coarse step while at least 4 positions remain.
    assign step_big = (rem_q >= BIG_CNT);

    rotl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i      (data_q),
        .big_i       (step_big),
        .fill_zero_i (fill_zero),
        .next_o      (data_d)
    );

    // Sequencer: load on an accepted start, iterate in RUN, and pulse done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        data_q  <= in;
                        rem_q   <= cnt;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rem_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        data_q <= data_d;
                        rem_q  <= step_big ? (rem_q - BIG_CNT) : (rem_q - SMALL_CNT);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = data_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : rotate_left_seq

// File: tb/tb_rotate_left_seq.sv
// Bench for rotate_left_seq.
// It uses random and directed operations with a scoreboard queue.
// The monitor pops one expected result each time done is seen.
module tb_rotate_left_seq;

`ifdef ROTL_SHIFT_MODE_EN
    localparam bit SHL_EN = 1'b1;
`else
    localparam bit SHL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_v = '0;
    logic [3:0]  cnt_v = '0;
    logic [15:0] out_v;
    logic        busy_v;
    logic        done_v;
`ifdef ROTL_SHIFT_MODE_EN
    logic        shl_v = 1'b0;
`endif

    typedef struct {
        logic [15:0] res;
        int          done_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          edge_cnt = 0;
    logic [15:0] last_res = '0;

    rotate_left_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_v),
        .cnt   (cnt_v),
`ifdef ROTL_SHIFT_MODE_EN
        .shl   (shl_v),
`endif
        .out   (out_v),
        .busy  (busy_v),
        .done  (done_v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the result is a plain multi-bit shift of the 16-bit operand, computed in 32 bits.
    // The low half is the shifted word; the high half holds the bits that wrapped out.
    function automatic logic [15:0] ref_result(input logic [15:0] a, input int c, input bit zero_fill);
        logic [31:0] w;
        w = {16'h0000, a} << c;
        if (zero_fill) return w[15:0];
        return w[15:0] | w[31:16];
    endfunction

    function automatic int lat(input int c);
        return c / 4 + c % 4;
    endfunction

    // Drive a start at the current negedge and push the expected response.
    task automatic issue(input logic [15:0] a, input logic [3:0] c, input bit s);
        exp_t e;
        start = 1'b1;
        in_v  = a;
        cnt_v = c;
`ifdef ROTL_SHIFT_MODE_EN
        shl_v = s;
`endif
        e.res       = ref_result(a, int'(c), s && SHL_EN);
        e.done_edge = edge_cnt + 1 + lat(int'(c)) + 1;
        last_res    = e.res;
        sb_q.push_back(e);
        $display("op in=0x%04h cnt=%0d shl=%0d exp=0x%04h done_edge=%0d",
                 a, c, s && SHL_EN, e.res, e.done_edge);
    endtask

    // Wait until the done cycle, counting busy cycles along the way.
    // With hold set, start stays high and in/cnt are scrambled during RUN.
    task automatic wait_done(input bit hold, input int exp_busy);
        int bc   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (done_v === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy_v === 1'b1) bc++;
                if (hold) begin
                    start = 1'b1;
                    in_v  = 16'($urandom);
                    cnt_v = 4'($urandom);
`ifdef ROTL_SHIFT_MODE_EN
                    shl_v = 1'($urandom);
`endif
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'(seen), 32'd1);
            start = 1'b0;
            sb_q.delete();
        end else begin
            chk("busy_cycles", bc, exp_busy);
        end
    endtask

    task automatic op(input logic [15:0] a, input logic [3:0] c, input bit s, input bit hold);
        issue(a, c, s);
        wait_done(hold, lat(int'(c)) + 1);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: whenever done is high, the front of the scoreboard must match.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done_v === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("done_with_empty_sb", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_v, e.res);
                    chk("done_edge", edge_cnt, e.done_edge);
                    chk("busy_at_done", busy_v, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [3:0]  c;
        bit          s;
        bit          hold;
        bit          b2b;

        // Asynchronous reset must act before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_out", out_v, 32'd0);
        chk("reset_busy", busy_v, 32'd0);
        chk("reset_done", done_v, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_v, 32'd0);
        chk("idle_done", done_v, 32'd0);

        // Directed cases.
        op(16'h2028, 4'd5, 1'b0, 1'b0);
        idle(1);
        if (SHL_EN) begin
            op(16'h2028, 4'd5, 1'b1, 1'b0);
            idle(1);
        end
        op(16'h0001, 4'd15, 1'b0, 1'b0);
        idle(1);
        op(16'h8001, 4'd1, 1'b0, 1'b0);
        idle(1);
        op(16'hBEEF, 4'd0, 1'b0, 1'b0);
        idle(3);
        chk("out_stable_idle", out_v, 32'h0000BEEF);

        // start held high through RUN with changing in/cnt, then a back-to-back start in DONE.
        op(16'h1234, 4'd9, 1'b0, 1'b1);
        op(16'hA5C3, 4'd6, 1'b0, 1'b0);
        idle(2);

        // Reset two cycles into a long operation discards it.
        issue(16'hFFFF, 4'd15, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_out", out_v, 32'd0);
        chk("midrun_rst_busy", busy_v, 32'd0);
        chk("midrun_rst_done", done_v, 32'd0);
        sb_q.delete();
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_v, 32'd0);
        chk("post_rst_done", done_v, 32'd0);
        chk("post_rst_out", out_v, 32'd0);

        // Random operations with random back-to-back and start-hold behaviour.
        for (int k = 0; k < 150; k++) begin
            a    = 16'($urandom);
            c    = 4'($urandom);
            s    = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            b2b  = 1'($urandom);
            op(a, c, s, hold);
            if (!b2b) begin
                idle($urandom_range(1, 3));
                chk("out_hold", out_v, last_res);
            end
        end

        idle(4);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rotate_left_seq
